sram_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares the single 4-bit × 256 SRAM controller between two requesters (port A, port B). It accepts one command per port, issues it to the controller's one-cycle write/read strobes, tracks the controller's `ready` through busy and back to idle, and returns a one-cycle acknowledge with read data. It sits between client logic and the SRAM controller and is the only master driving that controller.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 23 ++
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter: FSM states, port indices
// and the default ready timeout.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin picker; on a tie the port that was
// not granted last wins.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;

  always_comb begin
    gnt_idx = PORT_A;
    if (&req) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = PORT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between ports A and B: grants round-robin, issues
// a one-cycle strobe, follows ctl_ready busy->idle and acknowledges the winner.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TO_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_ack,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_ack,
  output logic [3:0] b_rdata,
  output logic       err,
  output logic       busy,
  output logic       ctl_write,
  output logic       ctl_read,
  output logic [7:0] ctl_address,
  output logic [3:0] ctl_data_write,
  input  logic [3:0] ctl_data_read,
  input  logic       ctl_ready
);

  state_e          state_q, state_d;
  logic            win_q, win_d;
  logic            last_q, last_d;
  logic            op_we_q, op_we_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [3:0]      wdata_q, wdata_d;
  logic [3:0]      a_rdata_q, a_rdata_d;
  logic [3:0]      b_rdata_q, b_rdata_d;
  logic            gnt_valid, gnt_idx;
  logic            timed_out;

  rr_arb2 u_rr (
    .req       ({b_req, a_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The counter saturates at the last wait cycle so a late WAIT_BUSY exit cannot wrap it.
  assign timed_out = (cnt_q >= TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_q     <= PORT_A;
      last_q    <= PORT_B;
      op_we_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      op_we_q   <= op_we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    op_we_d   = op_we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    err       = 1'b0;
    ctl_write = 1'b0;
    ctl_read  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctl_ready && gnt_valid) begin
          win_d   = gnt_idx;
          last_d  = gnt_idx;
          op_we_d = (gnt_idx == PORT_B) ? b_we    : a_we;
          addr_d  = (gnt_idx == PORT_B) ? b_addr  : a_addr;
          wdata_d = (gnt_idx == PORT_B) ? b_wdata : a_wdata;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ctl_write = op_we_q;
        ctl_read  = ~op_we_q;
        cnt_d     = '0;
        state_d   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = timed_out ? cnt_q : cnt_q + TO_W'(1);
        if (!ctl_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = timed_out ? cnt_q : cnt_q + TO_W'(1);
        if (ctl_ready) begin
          if (!op_we_q) begin
            if (win_q == PORT_B) b_rdata_d = ctl_data_read;
            else                 a_rdata_d = ctl_data_read;
          end
          state_d = ST_ACK;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        a_ack   = (win_q == PORT_A);
        b_ack   = (win_q == PORT_B);
        err     = err_q;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign ctl_address    = addr_q;
  assign ctl_data_write = wdata_q;
  assign a_rdata        = a_rdata_q;
  assign b_rdata        = b_rdata_q;

endmodule
